game_ctrl_lives: RTL
====================

# game_ctrl_lives

Parametrised game-flow controller for the snake game: the next generation of the single-life START/PLAY/END controller. It adds a lives counter, a timed DYING/respawn phase, an optional PAUSE state, configurable flash rate and an END-screen timeout. It sits between the key inputs, the snake collision logic and the VGA/score display, and drives the one-hot `Game_status` consumed by both.

## Interface
- `FLASH_DIV`, 12_500_000: clock cycles per `Flash_sig` half-period; ≥1.
- `LIVES`, 3: lives granted at game start; ≥1.
- `LIFE_W`, $clog2(LIVES+1): width of `Lives_left`.
- `DYING_FLASHES`, 4: full flash periods spent in DYING before respawn; ≥1.
- `END_TIMEOUT`, 500_000_000: cycles in END before automatic return to START; 0 disables the timeout.
- `SYNC_STAGES`, 2: key synchroniser depth; ≥2.

Ports:
- `Clk_50mhz` in 1: system clock; single clock domain.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `Key_left`, `Key_right`, `Key_up`, `Key_down` in 1 each: raw asynchronous direction keys, active-high.
- `Key_pause` in 1: raw asynchronous pause key, active-high.
- `Hit_wall_sig`, `Hit_body_sig` in 1 each: collision levels, synchronous to `Clk_50mhz`.
- `Game_status` out 5: one-hot state. START=00001, PLAY=00010, PAUSE=00100, DYING=01000, END=10000.
- `Lives_left` out LIFE_W: remaining lives.
- `Flash_sig` out 1: display blink.
- `Restart_pulse` out 1: one-cycle strobe telling the snake module to respawn.

## Operation
- Keys: each passes through a SYNC_STAGES-flop synchroniser, then a rising-edge detector producing a one-cycle pulse. `dir_evt` is the OR of the four direction pulses. Held keys give exactly one event.
- `hit` is `Hit_wall_sig | Hit_body_sig`, sampled directly with no synchroniser.

States:
- START: `Lives_left`=LIVES, `Flash_sig`=0. On `dir_evt`: go to PLAY and assert `Restart_pulse`.
- PLAY: `Flash_sig`=0.
  - `hit` with `Lives_left`>1: decrement lives, go to DYING.
  - `hit` with `Lives_left`==1: set lives to 0, go to END.
  - Pause event: go to PAUSE.
  - `hit` and pause event in the same cycle: `hit` wins.
- PAUSE: `Flash_sig`=1 steady. Pause event returns to PLAY. Direction keys and `hit` are ignored.
- DYING: `Flash_sig` toggles every FLASH_DIV cycles. After 2·DYING_FLASHES toggles, go to PLAY and assert `Restart_pulse` on the transition cycle. `Flash_sig` is forced to 0 on exit. `hit` and keys are ignored.
- END: `Flash_sig` toggles every FLASH_DIV cycles. Go to START on `dir_evt`, or when the timeout counter reaches END_TIMEOUT (if END_TIMEOUT≠0). Both in the same cycle cause a single transition. Pause is ignored.

Counters:
- The flash divider and the toggle counter clear on every state entry, so the first toggle comes FLASH_DIV cycles after entry.
- The timeout counter clears on END entry and saturates.
- Counter widths are $clog2 of their limits.
- `Lives_left` never underflows.

## Timing
- Reset values: `Game_status`=00001, `Lives_left`=LIVES, `Flash_sig`=0, `Restart_pulse`=0. All synchroniser, edge and counter flops are 0.
- Reset asserted mid-operation (e.g. mid-DYING) forces these values immediately, asynchronously.
- Key latency: a key sampled high at edge 1 changes `Game_status` at edge SYNC_STAGES+1.
- Hit latency: `hit` high at edge N updates state and lives at edge N. Outputs change after that edge.
- `Restart_pulse` is high for exactly one cycle, coincident with the first PLAY cycle.
- DYING lasts exactly 2·DYING_FLASHES·FLASH_DIV cycles.
- All outputs are registered.

## Configuration
- `GAME_CTRL_PAUSE_EN` defined: PAUSE state and `Key_pause` handling are compiled in, as described above.
- Undefined:
  - The `Key_pause` port stays but is ignored; its synchroniser is removed.
  - PAUSE is unreachable.
  - The 5-bit `Game_status` encoding is unchanged.

## Structure
- Shared package `game_pkg` holds:
  - state encodings `ST_START`, `ST_PLAY`, `ST_PAUSE`, `ST_DYING`, `ST_END`;
  - the `game_state_t` typedef (5-bit one-hot).
- One sub-module, `key_edge_sync` (parameter SYNC_STAGES; raw key in, one-cycle pulse out). It is instantiated once per key.

## Test plan
Bench parameters: FLASH_DIV=4, LIVES=2, DYING_FLASHES=2, END_TIMEOUT=50, SYNC_STAGES=2.
- Reset, then pulse `Key_up` for 3 cycles → `Game_status`=00010 three edges after the sample, `Restart_pulse` high 1 cycle, `Lives_left`=2.
- In PLAY, `Hit_wall_sig` for 1 cycle → DYING, `Lives_left`=1. `Flash_sig` toggles every 4 cycles, 4 toggles. After 16 cycles → PLAY with `Restart_pulse`=1, `Flash_sig`=0.
- Second hit via `Hit_body_sig` → END, `Lives_left`=0, `Flash_sig` toggling. No key for 50 cycles → START, `Lives_left`=2.
- END, then `Key_left` → START. Key held through START for 200 cycles → no second transition, stays START.
- `GAME_CTRL_PAUSE_EN` defined: PLAY, `Key_pause` → 00100, `Flash_sig`=1. Hit in PAUSE → ignored. `Key_pause` again → 00010. Hit and pause event in the same cycle → DYING.
- `Rst_n` low midway through DYING → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the snake game-flow controller: one-hot state
// encoding consumed by the display and score logic, plus a counter-width helper.
package game_pkg;

    typedef enum logic [4:0] {
        ST_START = 5'b00001,
        ST_PLAY  = 5'b00010,
        ST_PAUSE = 5'b00100,
        ST_DYING = 5'b01000,
        ST_END   = 5'b10000
    } game_state_t;

    // $clog2 of a limit, never narrower than one bit so degenerate limits still build.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Raw asynchronous key -> SYNC_STAGES-flop synchroniser -> one-cycle pulse on
// the synchronised rising edge. A held key yields exactly one pulse.
module key_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key_raw};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Combinational so a key seen at edge 1 moves the FSM at edge SYNC_STAGES+1.
    assign key_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/game_ctrl_lives.sv
// Snake game-flow controller with lives, timed DYING/respawn and END timeout.
// Define GAME_CTRL_PAUSE_EN to compile in the PAUSE state and Key_pause handling.
module game_ctrl_lives
    import game_pkg::*;
#(
    parameter int FLASH_DIV     = 12_500_000,
    parameter int LIVES         = 3,
    parameter int LIFE_W        = $clog2(LIVES + 1),
    parameter int DYING_FLASHES = 4,
    parameter int END_TIMEOUT   = 500_000_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              Clk_50mhz,
    input  logic              Rst_n,
    input  logic              Key_left,
    input  logic              Key_right,
    input  logic              Key_up,
    input  logic              Key_down,
    input  logic              Key_pause,
    input  logic              Hit_wall_sig,
    input  logic              Hit_body_sig,
    output logic [4:0]        Game_status,
    output logic [LIFE_W-1:0] Lives_left,
    output logic              Flash_sig,
    output logic              Restart_pulse
);

    localparam int DIV_W = cnt_width(FLASH_DIV);
    localparam int TGL_W = cnt_width(2 * DYING_FLASHES);
    localparam int TMO_W = cnt_width(END_TIMEOUT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(FLASH_DIV - 1);
    localparam logic [TGL_W-1:0]  TGL_LAST   = TGL_W'(2 * DYING_FLASHES - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(END_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'((END_TIMEOUT == 0) ? 0 : END_TIMEOUT - 1);
    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
    localparam logic [LIFE_W-1:0] LIFE_ONE   = LIFE_W'(1);

    // ------------------------------------------------------------------
    // Key conditioning
    // ------------------------------------------------------------------
    logic [3:0] dir_raw;
    logic [3:0] dir_pulse;
    logic       dir_evt;
    logic       pause_evt;
    logic       hit;

    assign dir_raw = {Key_down, Key_up, Key_right, Key_left};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dir_sync
            key_edge_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_dir_sync (
                .clk      (Clk_50mhz),
                .rst_n    (Rst_n),
                .key_raw  (dir_raw[gi]),
                .key_pulse(dir_pulse[gi])
            );
        end
    endgenerate

    assign dir_evt = |dir_pulse;

`ifdef GAME_CTRL_PAUSE_EN
    key_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pause_sync (
        .clk      (Clk_50mhz),
        .rst_n    (Rst_n),
        .key_raw  (Key_pause),
        .key_pulse(pause_evt)
    );
`else
    logic pause_unused;
    assign pause_unused = Key_pause;
    assign pause_evt    = 1'b0;
`endif

    // Collision levels are already in this clock domain.
    assign hit = Hit_wall_sig | Hit_body_sig;

    // ------------------------------------------------------------------
    // State, lives, flash and counters
    // ------------------------------------------------------------------
    game_state_t       state_q, state_d;
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic              flash_q, flash_d;
    logic              restart_q, restart_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TGL_W-1:0]  tgl_q, tgl_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              div_last;

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        flash_d   = flash_q;
        restart_d = 1'b0;
        div_d     = '0;
        tgl_d     = tgl_q;
        tmo_d     = '0;

        case (state_q)
            ST_START: begin
                lives_d = LIVES_INIT;
                flash_d = 1'b0;
                if (dir_evt) begin
                    state_d   = ST_PLAY;
                    restart_d = 1'b1;
                end
            end

            ST_PLAY: begin
                flash_d = 1'b0;
                // Collision outranks a simultaneous pause request.
                if (hit) begin
                    if (lives_q > LIFE_ONE) begin
                        lives_d = lives_q - LIFE_ONE;
                        state_d = ST_DYING;
                    end else begin
                        lives_d = '0;
                        state_d = ST_END;
                    end
                end else if (pause_evt) begin
                    state_d = ST_PAUSE;
                    flash_d = 1'b1;
                end
            end

            ST_PAUSE: begin
                flash_d = 1'b1;
                if (pause_evt) begin
                    state_d = ST_PLAY;
                    flash_d = 1'b0;
                end
            end

            ST_DYING: begin
                if (div_last) begin
                    flash_d = ~flash_q;
                    tgl_d   = tgl_q + TGL_W'(1);
                    if (tgl_q == TGL_LAST) begin
                        state_d   = ST_PLAY;
                        restart_d = 1'b1;
                        flash_d   = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_END: begin
                if (div_last) begin
                    flash_d = ~flash_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
                if (dir_evt || ((END_TIMEOUT != 0) && (tmo_q == TMO_LAST))) begin
                    state_d = ST_START;
                    lives_d = LIVES_INIT;
                    flash_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_START;
                lives_d = LIVES_INIT;
                flash_d = 1'b0;
            end
        endcase

        // Every state entry restarts the flash phase and END timeout.
        if (state_d != state_q) begin
            div_d = '0;
            tgl_d = '0;
            tmo_d = '0;
        end
    end

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_START;
            lives_q   <= LIVES_INIT;
            flash_q   <= 1'b0;
            restart_q <= 1'b0;
            div_q     <= '0;
            tgl_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            flash_q   <= flash_d;
            restart_q <= restart_d;
            div_q     <= div_d;
            tgl_q     <= tgl_d;
            tmo_q     <= tmo_d;
        end
    end

    assign Game_status   = state_q;
    assign Lives_left    = lives_q;
    assign Flash_sig     = flash_q;
    assign Restart_pulse = restart_q;

endmodule
